// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per clock, result = {remainder, quotient}.
// Signed (two's-complement) division is compiled in only when DIV_SIGNED_EN is defined.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state
);

  // Handshake: start_i is sampled only in S_IDLE and must be held until ready_o is seen;
  // ready_o stays high with a stable result_o until start_i is sampled low.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             accept;

  assign accept    = (state == S_IDLE) && start_i && !annul_i;
  assign busy_o    = (state == S_BYZERO) || (state == S_ON);
  assign dbg_state = state;

`ifdef DIV_SIGNED_EN
  logic sign1;
  logic sign2;
  logic neg_q;
  logic neg_r;

  assign sign1   = signed_i & opdata1_i[WIDTH-1];
  assign sign2   = signed_i & opdata2_i[WIDTH-1];
  assign mag1    = sign1 ? (-opdata1_i) : opdata1_i;
  assign mag2    = sign2 ? (-opdata2_i) : opdata2_i;
  // Quotient negated on sign mismatch; remainder follows the dividend's sign.
  assign quo_fix = neg_q ? (-quo) : quo;
  assign rem_fix = neg_r ? (-rem) : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= sign1 ^ sign2;
      neg_r <= sign1;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign mag1          = opdata1_i;
  assign mag2          = opdata2_i;
  assign quo_fix       = quo;
  assign rem_fix       = rem;
`endif

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end
      S_BYZERO: begin
        state_next = annul_i ? S_IDLE : S_END;
      end
      S_ON: begin
        if (annul_i) begin
          state_next = S_IDLE;
        end else if (cnt == LAST_STEP) begin
          state_next = S_END;
        end
      end
      S_END: begin
        if (ready_o && !start_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= '0;
            rem <= '0;
            quo <= mag1;
            dvs <= mag2;
          end
        end
        S_BYZERO: begin
          rem <= '0;
          quo <= '0;
        end
        S_ON: begin
          if (!annul_i) begin
            cnt <= cnt + 1'b1;
            if (!trial[WIDTH]) begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end
        end
        S_END: begin
          // First END cycle publishes the result; it is cleared on the way back to idle.
          if (!ready_o) begin
            ready_o  <= 1'b1;
            result_o <= {rem_fix, quo_fix};
          end else if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter (WIDTH=32): directed vector table, annul/reset sequences and
// randomized divisions checked against a plain-arithmetic reference model.
module tb_div_iter;

  localparam int W = 32;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           sgn;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic           annul;
  logic [2*W-1:0] result;
  logic           ready;
  logic           busy;
  logic [1:0]     dbg_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic           s;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  div_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .signed_i  (sgn),
    .opdata1_i (op1),
    .opdata2_i (op2),
    .annul_i   (annul),
    .result_o  (result),
    .ready_o   (ready),
    .busy_o    (busy),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: truncating division, remainder takes the dividend's sign, x/0 -> 0.
  function automatic logic [2*W-1:0] ref_div(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == '0) return '0;
    if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  task automatic run_div(input string name, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    sgn   = s;
    op1   = a;
    op2   = b;
    @(posedge clk);
    #1;
    op1      = $urandom;
    op2      = $urandom;
    sgn      = 1'($urandom_range(0, 1));
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      if (busy) busy_cnt++;
      if (ready) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("%s latency", name), seen ? 64'(lat) : 64'hFFFF, (b == '0) ? 64'd2 : 64'(W + 1));
    check($sformatf("%s busy_cycles", name), 64'(busy_cnt), (b == '0) ? 64'd1 : 64'(W));
    check($sformatf("%s result", name), result, exp);
    @(posedge clk);
    #1;
    check($sformatf("%s hold", name), {63'h0, ready}, 64'd1);
    check($sformatf("%s hold_result", name), result, exp);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("%s release", name), {ready, busy, dbg_state, result}, '0);
  endtask

  task automatic watch_no_ready(input string name, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ready || result != '0) seen = 1'b1;
    end
    check($sformatf("%s no_ready", name), {63'h0, seen}, 64'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,
                 SIGNED_EN ? {32'hFFFFFFFE, 32'hFFFFFFF2} : {32'd2, 32'h24924916}};
    vecs[2]  = '{1'b0, 32'h12345678,   32'd0,          64'd0};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,
                 SIGNED_EN ? {32'h0, 32'h80000000} : {32'h80000000, 32'h0}};
    vecs[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0}};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          {32'h0, 32'hFFFFFFFF}};
    vecs[6]  = '{1'b0, 32'd5,          32'd10,         {32'd5, 32'd0}};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0, 32'd1}};
    vecs[8]  = '{1'b0, 32'hDEADBEEF,   32'h00010000,   {32'h0000BEEF, 32'h0000DEAD}};
    vecs[9]  = '{1'b1, 32'd7,          32'hFFFFFFFE,
                 SIGNED_EN ? {32'd1, 32'hFFFFFFFD} : {32'd7, 32'd0}};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,
                 SIGNED_EN ? {32'hFFFFFFFF, 32'd3} : {32'hFFFFFFF9, 32'd0}};

    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    op1   = '0;
    op2   = '0;
    annul = 1'b0;
    #3;
    check("reset outputs", {ready, busy, dbg_state, result}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle after reset", {ready, busy, dbg_state, result}, '0);

    for (int i = 0; i < 11; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Annul during ON, then a fresh division must still be correct.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("annul_on busy_before", {63'h0, busy}, 64'd1);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul_on idle", {ready, busy, dbg_state}, '0);
    @(negedge clk);
    annul = 1'b0;
    watch_no_ready("annul_on", W + 5);
    run_div("after_annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

    // Annul during BYZERO.
    @(negedge clk);
    start = 1'b1; op1 = 32'h12345678; op2 = 32'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    annul = 1'b1;
    @(posedge clk);
    #1;
    check("annul_byzero idle", {ready, busy, dbg_state}, '0);
    @(negedge clk);
    annul = 1'b0;
    watch_no_ready("annul_byzero", 4);

    // Annul has priority over start in IDLE.
    @(negedge clk);
    start = 1'b1; annul = 1'b1; op1 = 32'd50; op2 = 32'd3;
    @(posedge clk);
    #1;
    check("annul_priority idle", {ready, busy, dbg_state}, '0);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    watch_no_ready("annul_priority", W + 5);

    // Asynchronous reset in the middle of ON.
    @(negedge clk);
    start = 1'b1; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst outputs", {ready, busy, dbg_state, result}, '0);
    @(negedge clk);
    rst = 1'b0;
    watch_no_ready("midrst", W + 5);
    run_div("after_rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});

    for (int i = 0; i < 40; i++) begin
      logic           s;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      s = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFFFFFF;
        3:       b = 32'd1;
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), s, a, b, ref_div(s, a, b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_iter.md
DIV_ITER -- requirements
Module: div_iter

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand width in bits; legal range 8..64.
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port start_i  input  1  request to begin a division; only sampled in IDLE.
REQ-005 SHALL provide port signed_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start_i.
REQ-006 SHALL provide port opdata1_i  input  WIDTH  dividend; sampled with start_i.
REQ-007 SHALL provide port opdata2_i  input  WIDTH  divisor; sampled with start_i.
REQ-008 SHALL provide port annul_i  input  1  cancel an in-flight division (pipeline flush).
REQ-009 SHALL provide port result_o  output  2*WIDTH  {remainder, quotient}; the upper half feeds HI, the lower half feeds LO.
REQ-010 SHALL provide port ready_o  output  1  result_o valid.
REQ-011 SHALL provide port busy_o  output  1  high in BYZERO and ON; drives the pipeline stall request.

Function
REQ-012 SHALL implement four states: IDLE, BYZERO, ON, END.
REQ-013 SHALL, in IDLE with start_i=1 and annul_i=0, capture the operands and go to BYZERO if opdata2_i==0, else to ON with the iteration counter cleared.
REQ-014 SHALL perform one restoring shift-subtract step per cycle in ON, using a WIDTH+1-bit trial subtraction; it SHALL go to END after exactly WIDTH steps.
REQ-015 SHALL spend exactly one cycle in BYZERO, then go to END with quotient=0 and remainder=0.
REQ-016 SHALL assert ready_o starting WIDTH+1 cycles after the start edge for a nonzero divisor, and 2 cycles after it for a zero divisor.
REQ-017 SHALL hold ready_o=1 and a stable result_o in END until start_i is sampled 0; it SHALL then return to IDLE.
REQ-018 SHALL drive result_o=0 and ready_o=0 in every state other than END.
REQ-019 SHALL, for a signed divide, divide the operand magnitudes; it SHALL negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-020 SHALL produce quotient = most-negative value and remainder = 0 for (most-negative)/(-1) signed, wrapping modulo 2^WIDTH, with no flag.
REQ-021 SHALL, when annul_i=1 in BYZERO or ON, return to IDLE on the next edge; ready_o SHALL stay 0 and the partial result SHALL be discarded.
REQ-022 SHALL give annul_i priority over start_i in IDLE, so no division starts.
REQ-023 SHALL ignore start_i and operand changes while in BYZERO or ON.

Reset
REQ-024 SHALL, while rst=1, immediately force state=IDLE, counter=0, dividend/divisor registers=0, result_o=0, ready_o=0, busy_o=0, regardless of clk.
REQ-025 SHALL abandon any division in progress when rst asserts mid-operation; no ready_o pulse SHALL follow the release of reset.

Configuration
REQ-026 SHALL honour signed_i per REQ-019/020 when DIV_SIGNED_EN is defined.
REQ-027 SHALL ignore signed_i and treat all operands as unsigned when DIV_SIGNED_EN is undefined; no sign-correction logic SHALL be synthesised.

Verification
REQ-028 SHALL cover: WIDTH=32, unsigned 100/7 -> ready_o after 33 cycles, result_o={32'd2, 32'd14}.
REQ-029 SHALL cover: signed -100/7 (DIV_SIGNED_EN) -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE.
REQ-030 SHALL cover: 0x12345678/0 -> busy_o for 1 cycle, ready_o at cycle 2, result_o=0.
REQ-031 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-032 SHALL cover: annul_i pulsed at cycle 10 of ON -> IDLE next cycle, ready_o never asserts, and a new start runs to a correct result.
REQ-033 SHALL cover: rst asserted mid-ON between clock edges -> outputs 0 immediately; 100/7 after release -> correct result.
